// File: rtl/fpu_f32_div_sequencer.sv
// fpu_f32_div_sequencer: registered, backpressure-safe front/back end for a combinational F32 divider.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            request handshake (ready = FIFO not full, from registered count)
//   req_a_i, req_b_i, req_tag_i        dividend, divisor, tag
//   div_a_o, div_b_o                   registered operands driven to the divider
//   div_o_i                            divider quotient, combinational from div_a_o/div_b_o
//   rsp_valid_o/rsp_ready_i            response handshake
//   rsp_data_o, rsp_tag_o, rsp_flags_o captured quotient, tag, flags {NV, DZ}
//   busy_o                             FIFO non-empty or an operation in flight/held
module fpu_f32_div_sequencer #(
    parameter int TAG_WIDTH     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_a_i,
    input  logic [31:0]          req_b_i,
    input  logic [TAG_WIDTH-1:0] req_tag_i,
    output logic [31:0]          div_a_o,
    output logic [31:0]          div_b_o,
    input  logic [31:0]          div_o_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic [TAG_WIDTH-1:0] rsp_tag_o,
    output logic [1:0]           rsp_flags_o,
    output logic                 busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 64 + TAG_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [31:0]          div_a_q, div_a_d, div_b_q, div_b_d;
    logic [TAG_WIDTH-1:0] op_tag_q, op_tag_d, rsp_tag_q, rsp_tag_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_flags_q, rsp_flags_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 push, pop, not_empty;
    logic                 a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    assign not_empty   = count_q != '0;
    assign req_ready_o = count_q != CW'(FIFO_DEPTH);
    assign push        = req_valid_i & req_ready_o;
    // The head is only consumed when the engine is free: idle, or its held response leaves this edge.
    assign pop         = not_empty & (state_q == IDLE | (state_q == HOLD & rsp_ready_i));

    assign a_nan  = (&div_a_q[30:23]) & (|div_a_q[22:0]);
    assign a_inf  = (&div_a_q[30:23]) & ~(|div_a_q[22:0]);
    assign a_zero = ~(|div_a_q[30:0]);
    assign b_nan  = (&div_b_q[30:23]) & (|div_b_q[22:0]);
    assign b_inf  = (&div_b_q[30:23]) & ~(|div_b_q[22:0]);
    assign b_zero = ~(|div_b_q[30:0]);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {req_a_i, req_b_i, req_tag_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_q  <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        op_tag_d    = op_tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = div_o_i;
                    rsp_tag_d   = op_tag_q;
                    rsp_flags_d = {a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf),
                                   b_zero & ~a_nan & ~a_inf & ~a_zero};
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase
        // A pop overrides IDLE/HOLD exit so a queued op starts on the same edge the previous one retires.
        if (pop) begin
            {div_a_d, div_b_d, op_tag_d} = mem_q[rd_ptr_q];
            cnt_d   = 4'(SETTLE_CYCLES - 1);
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            op_tag_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            op_tag_q    <= op_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_flags_o = rsp_flags_q;
    assign busy_o      = not_empty | (state_q != IDLE);
endmodule

// File: tb/tb_fpu_f32_div_sequencer.sv
// tb_fpu_f32_div_sequencer: table-driven and scoreboard bench for the divider sequencer (SETTLE 1 and 3).
module tb_fpu_f32_div_sequencer;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] d;
        logic [1:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, busy;
    logic [31:0] req_a = '0, req_b = '0, div_a, div_b, div_o, rsp_data;
    logic [3:0]  req_tag = '0, rsp_tag;
    logic [1:0]  rsp_flags;
    logic        req_valid2 = 1'b0, req_ready2, rsp_valid2, rsp_ready2 = 1'b1, busy2;
    logic [31:0] req_a2 = '0, req_b2 = '0, div_a2, div_b2, div_o2, rsp_data2;
    logic [3:0]  req_tag2 = '0, rsp_tag2;
    logic [1:0]  rsp_flags2;

    int   n_cmp = 0, n_fail = 0, cyc = 0, last_hs = -1;
    bit   spacing_en = 1'b0;
    vec_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    // Stand-in divider: exact quotients for the known operand pairs, a scrambling function otherwise.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
        if (a == 32'h00000000 && b == 32'h80000000) return 32'h7FC00000;
        if (a == 32'h41200000 && b == 32'h40A00000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h12345678;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                                input logic [1:0] f);
        vec_t v;
        v.a = a; v.b = b; v.tag = tag; v.f = f; v.d = div_model(a, b);
        return v;
    endfunction

    assign div_o  = div_model(div_a, div_b);
    assign div_o2 = div_model(div_a2, div_b2);

    fpu_f32_div_sequencer #(.TAG_WIDTH(4), .FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag), .div_a_o(div_a), .div_b_o(div_b),
        .div_o_i(div_o), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_tag_o(rsp_tag), .rsp_flags_o(rsp_flags), .busy_o(busy));

    fpu_f32_div_sequencer #(.TAG_WIDTH(4), .FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_a_i(req_a2), .req_b_i(req_b2), .req_tag_i(req_tag2), .div_a_o(div_a2), .div_b_o(div_b2),
        .div_o_i(div_o2), .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2),
        .rsp_tag_o(rsp_tag2), .rsp_flags_o(rsp_flags2), .busy_o(busy2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake happens at the next rising edge iff valid & ready at the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got tag %0h data %0h, expected none", rsp_tag, rsp_data);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.d));
                check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                check("rsp_flags", 64'(rsp_flags), 64'(e.f));
                if (spacing_en && last_hs >= 0) check("rsp_spacing", 64'(cyc - last_hs), 64'd2);
                last_hs = cyc;
            end
        end
    end

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        req_valid = 1'b1; req_a = v.a; req_b = v.b; req_tag = v.tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: req_ready stayed %0b, expected 1", req_ready);
            req_valid = 1'b0;
        end else begin
            sb.push_back(v);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("drain_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(32'h40C00000, 32'h40000000, 4'd3, 2'b00);
        vecs[1]  = mk(32'h3F800000, 32'h00000000, 4'd1, 2'b01);
        vecs[2]  = mk(32'h00000000, 32'h80000000, 4'd2, 2'b10);
        vecs[3]  = mk(32'h7F800000, 32'h7F800000, 4'd4, 2'b10);
        vecs[4]  = mk(32'h7FC00001, 32'h3F800000, 4'd5, 2'b10);
        vecs[5]  = mk(32'h3F800000, 32'hFF800001, 4'd6, 2'b10);
        vecs[6]  = mk(32'h7F800000, 32'h00000000, 4'd7, 2'b00);
        vecs[7]  = mk(32'h80000000, 32'h00000000, 4'd8, 2'b10);
        vecs[8]  = mk(32'hC0000000, 32'h80000000, 4'd9, 2'b01);
        vecs[9]  = mk(32'h3F800000, 32'h7F800000, 4'hA, 2'b00);
        vecs[10] = mk(32'h00000001, 32'h00000000, 4'hB, 2'b01);
        vecs[11] = mk(32'hFF800000, 32'h3F800000, 4'hC, 2'b00);

        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_div_a", 64'(div_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-op latency on an idle block: valid becomes visible after E0+2.
        req_valid = 1'b1; req_a = vecs[0].a; req_b = vecs[0].b; req_tag = vecs[0].tag;
        @(negedge clk);
        check("lat_ready", 64'(req_ready), 64'd1);
        sb.push_back(vecs[0]);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_e0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_e1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_e2", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Whole table back-to-back with the consumer always ready.
        for (int i = 0; i < 12; i++) send(vecs[i]);
        req_valid = 1'b0;
        drain();

        // Backpressure: tag0 held, tags 1-4 fill the FIFO, tag5 stalls.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vecs[i];
            v.tag = 4'(i);
            send(v);
        end
        req_a = vecs[5].a; req_b = vecs[5].b; req_tag = 4'd5;
        repeat (3) begin
            @(negedge clk);
            check("full_req_ready", 64'(req_ready), 64'd0);
            check("held_valid", 64'(rsp_valid), 64'd1);
            check("held_tag", 64'(rsp_tag), 64'd0);
        end
        @(posedge clk);
        #1;
        spacing_en = 1'b1;
        last_hs = -1;
        rsp_ready = 1'b1;
        begin
            vec_t v;
            v = vecs[5];
            v.tag = 4'd5;
            send(v);
        end
        req_valid = 1'b0;
        drain();
        spacing_en = 1'b0;

        // Async reset with a held response and a queued op.
        rsp_ready = 1'b0;
        send(vecs[8]);
        send(vecs[9]);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_div", 64'({div_a, div_b}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("arst_no_stale", 64'(rsp_valid), 64'd0);
        end

        // SETTLE=3: operands stable for the whole window, capture after E0+4.
        @(posedge clk);
        #1;
        req_valid2 = 1'b1; req_a2 = 32'h41200000; req_b2 = 32'h40A00000; req_tag2 = 4'd7;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("s3_div_a", 64'(div_a2), 64'h41200000);
            check("s3_div_b", 64'(div_b2), 64'h40A00000);
            check("s3_valid", 64'(rsp_valid2), 64'(j == 4));
        end
        check("s3_data", 64'(rsp_data2), 64'h40000000);
        check("s3_tag", 64'(rsp_tag2), 64'd7);
        check("s3_flags", 64'(rsp_flags2), 64'd0);

        // Reset while in WAIT with two queued; only the post-reset request may answer.
        @(posedge clk);
        #1;
        for (int t = 1; t <= 3; t++) begin
            req_valid2 = 1'b1; req_a2 = 32'h3F800000; req_b2 = 32'h40000000 + 32'(t); req_tag2 = 4'(t);
            @(posedge clk);
            #1;
        end
        req_valid2 = 1'b0;
        check("w_busy_before", 64'(busy2), 64'd1);
        rst_n = 1'b0;
        #1;
        check("w_rst_busy", 64'(busy2), 64'd0);
        check("w_rst_valid", 64'(rsp_valid2), 64'd0);
        check("w_rst_div", 64'({div_a2, div_b2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (rsp_valid2) seen++;
            end
            check("w_no_stale", 64'(seen), 64'd0);
        end
        @(posedge clk);
        #1;
        req_valid2 = 1'b1; req_a2 = 32'h41200000; req_b2 = 32'h40A00000; req_tag2 = 4'd9;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rsp_valid2) begin got = 1'b1; break; end
            end
            check("w_new_valid", 64'(got), 64'd1);
            check("w_new_tag", 64'(rsp_tag2), 64'd9);
            check("w_new_data", 64'(rsp_data2), 64'h40000000);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1);
    end
endmodule
